// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-channel SRAM-like bus arbiter with in-order response routing
//
// Ports:
//   clk, resetn                  single clock, asynchronous active-low reset
//   m_req, m_wr [NCH]            per-channel request / write flag
//   m_size [2*NCH]               per-channel transfer size
//   m_addr, m_wdata [32*NCH]     per-channel address / write data (channel i at [32i+31:32i])
//   m_addr_ok, m_data_ok [NCH]   per-channel address accept / response strobe
//   m_rdata [32]                 response data, broadcast to all channels
//   s_req, s_wr, s_size,
//   s_addr, s_wdata              slave request side, driven from the granted channel
//   s_addr_ok, s_data_ok,
//   s_rdata                      slave accept / response side
//   outstanding                  accepted-but-unanswered transaction count
//   err_unexp                    sticky flag: response arrived with nothing in flight
module sram_like_arbiter #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int RR    = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NCH-1:0]           m_req,
    input  logic [NCH-1:0]           m_wr,
    input  logic [2*NCH-1:0]         m_size,
    input  logic [32*NCH-1:0]        m_addr,
    input  logic [32*NCH-1:0]        m_wdata,
    output logic [NCH-1:0]           m_addr_ok,
    output logic [NCH-1:0]           m_data_ok,
    output logic [31:0]              m_rdata,
    output logic                     s_req,
    output logic                     s_wr,
    output logic [1:0]               s_size,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    input  logic [31:0]              s_rdata,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_unexp
);

    localparam int IDW = $clog2(NCH);
    localparam int PW  = $clog2(DEPTH);
    localparam int OW  = PW + 1;

    logic             lock_v;
    logic [IDW-1:0]   lock_id;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [IDW-1:0]   arb_id;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   head_id;
    logic             full;
    logic             empty;
    logic             hs;
    logic             pop;

    assign full  = (outstanding == OW'(DEPTH));
    assign empty = (outstanding == '0);

    // Free arbitration. Loops run from lowest to highest priority so the
    // last matching assignment is the winner.
    always_comb begin
        logic [IDW-1:0] idx;
        arb_id = '0;
        idx    = '0;
        if (RR == 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (m_req[i]) arb_id = IDW'(i);
            end
        end else begin
            // k = NCH is 'last' itself (lowest), k = 1 is last+1 (highest)
            for (int k = NCH; k >= 1; k--) begin
                idx = IDW'((int'(last) + k) % NCH);
                if (m_req[idx]) arb_id = idx;
            end
        end
    end

    // A stalled request keeps its channel until accepted, so the slave
    // never sees its address/data change mid-handshake.
    assign grant_id = lock_v ? lock_id : arb_id;
    assign s_req    = (|m_req) & ~full;
    assign hs       = s_req & s_addr_ok;
    assign head_id  = fifo_mem[rd_ptr];
    assign pop      = s_data_ok & ~empty;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        m_rdata   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s_req && grant_id == IDW'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_addr  = m_addr[32*i +: 32];
                s_wdata = m_wdata[32*i +: 32];
            end
            m_addr_ok[i] = hs && (grant_id == IDW'(i));
            m_data_ok[i] = pop && (head_id == IDW'(i));
        end
        if (pop) m_rdata = s_rdata;
    end

    // ID storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (hs) fifo_mem[wr_ptr] <= grant_id;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_v      <= 1'b0;
            lock_id     <= '0;
            last        <= IDW'(NCH - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_unexp   <= 1'b0;
        end else begin
            if (hs) begin
                lock_v <= 1'b0;
            end else if (s_req) begin
                lock_v  <= 1'b1;
                lock_id <= grant_id;
            end
            if (hs && RR != 0) last <= grant_id;
            if (hs)  wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (hs && !pop)      outstanding <= outstanding + OW'(1);
            else if (!hs && pop) outstanding <= outstanding - OW'(1);
            if (s_data_ok && empty) err_unexp <= 1'b1;
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of master channels (ch0=inst, ch1=data); legal range 2..8.
REQ-002 SHALL have parameter DEPTH, default 4, maximum outstanding accepted-but-unanswered transactions; power of two, 2..16.
REQ-003 SHALL have parameter RR, default 0, arbitration mode: 0 = fixed priority with lowest index winning, 1 = round-robin.
REQ-004 SHALL have clock port clk, input, 1 bit, the single clock; reset is asynchronous and active-low.
REQ-005 SHALL have reset port resetn, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have m_req, m_wr, input, NCH bits each: per-channel request and write flag.
REQ-007 SHALL have m_size, input, 2*NCH bits (2 per channel); m_addr and m_wdata, input, 32*NCH bits each (channel i at slice [32i+31:32i]).
REQ-008 SHALL have m_addr_ok and m_data_ok, output, NCH bits each; m_rdata, output, 32 bits, broadcast to all channels.
REQ-009 SHALL have slave outputs s_req (1), s_wr (1), s_size (2), s_addr (32) and s_wdata (32).
REQ-010 SHALL have slave inputs s_addr_ok (1), s_data_ok (1) and s_rdata (32).
REQ-011 SHALL have outputs outstanding, $clog2(DEPTH)+1 bits, the current in-flight count; and err_unexp, 1 bit, sticky flag for an unexpected response.

Function
REQ-012 SHALL compute the grant combinationally as one-hot over m_req: RR=0 picks the lowest set index; RR=1 picks the first set index at or after (last+1) mod NCH.
REQ-013 SHALL drive s_req = (|m_req) & (outstanding != DEPTH), with s_wr, s_size, s_addr and s_wdata taken from the granted channel.
REQ-014 SHALL drive s_wr, s_size, s_addr and s_wdata to 0 when s_req=0.
REQ-015 SHALL define an address handshake as s_req & s_addr_ok; m_addr_ok[g] SHALL equal that handshake for the granted channel g and SHALL be 0 for all other channels.
REQ-016 SHALL, when s_req=1 and s_addr_ok=0, lock the grant (lock_v, lock_id registered) so it holds unchanged on following cycles until the handshake, even if a higher-priority channel raises m_req.
REQ-017 SHALL clear the lock on the handshake cycle; masters are obliged to hold m_req and their fields stable until m_addr_ok.
REQ-018 SHALL update last to the granted index only on a handshake cycle when RR=1; last SHALL never change when RR=0.
REQ-019 SHALL, on each handshake, push the granted channel index into an in-order ID FIFO of DEPTH entries with wrapping read and write pointers.
REQ-020 SHALL, on s_data_ok with FIFO non-empty, pop the head and assert m_data_ok[head] for that cycle only, with m_rdata = s_rdata in the same cycle (zero added latency).
REQ-021 SHALL drive m_rdata to 0 whenever no m_data_ok bit is asserted.
REQ-022 SHALL, on s_data_ok with FIFO empty, assert no m_data_ok bit, leave outstanding unchanged and set err_unexp=1 from the next cycle until reset.
REQ-023 SHALL perform both push and pop when they occur in the same cycle, leaving outstanding unchanged.
REQ-024 SHALL hold s_req=0 while full, even in a cycle with a pop, so the full boundary is never exceeded; the lock SHALL persist through a full stall.
REQ-025 SHALL allow a handshake and a response for the same channel in the same cycle, with the response belonging to the older entry.
REQ-026 SHALL give outstanding a register update of +1 on push only, -1 on pop only, and 0 otherwise.

Reset
REQ-027 SHALL, on resetn=0 at any time (including mid-transaction), asynchronously clear: FIFO pointers, outstanding=0, lock_v=0, last=NCH-1 (so ch0 has first RR priority), err_unexp=0.
REQ-028 SHALL keep all outputs derived from state during reset: m_data_ok=0, m_addr_ok=0, s_req=0 while m_req=0.
REQ-029 SHALL discard in-flight transactions lost by reset; responses arriving after reset SHALL set err_unexp.

Verification
REQ-030 Fixed priority: RR=0, m_req=2'b11, s_addr_ok=1 -> ch0 granted every cycle, m_addr_ok=2'b01; when ch0 drops, ch1 granted next cycle.
REQ-031 Lock: ch1 alone requests addr 0x1000, s_addr_ok=0 for 3 cycles; ch0 raises req in cycle 2 -> s_addr=0x1000 held and grant stays ch1 until s_addr_ok; ch0 served next cycle.
REQ-032 Round-robin: RR=1, NCH=4, all m_req=1, s_addr_ok=1 -> grant order 0,1,2,3,0; outstanding rises to DEPTH, then s_req=0.
REQ-033 In-order return: accept ch1, ch0, ch1; three s_data_ok pulses with rdata 0xA, 0xB, 0xC -> m_data_ok 2'b10/0xA, 2'b01/0xB, 2'b10/0xC.
REQ-034 Full boundary: DEPTH=4 with 4 outstanding, pending request plus s_data_ok in the same cycle -> no handshake that cycle, outstanding=3, then handshake next cycle, outstanding=4.
REQ-035 Unexpected response and reset: s_data_ok with outstanding=0 -> m_data_ok=0 and err_unexp=1 next cycle; resetn pulse with 2 outstanding -> outstanding=0 and err_unexp=0 immediately.
